muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result bundle between the pipeline and the
// multiply/divide unit.
//   Start     : one-cycle request qualifier for MDOp
//   MDOp      : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B      : operands rs / rt
//   ReadSel   : 0 selects LO, 1 selects HI onto MULDIVOut
//   Busy      : high while a mult/div is in flight
//   MULDIVOut : committed HI or LO, combinational on ReadSel
interface muldiv_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadSel;
    logic        Busy;
    logic [31:0] MULDIVOut;

    modport master (
        output Start, MDOp, A, B, ReadSel,
        input  Busy, MULDIVOut
    );

    modport slave (
        input  Start, MDOp, A, B, ReadSel,
        output Busy, MULDIVOut
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- MIPS-style HI/LO multiply/divide unit with a fixed-latency
// busy window.
//   clk   : single clock, all state updates on posedge
//   reset : asynchronous, active-high; clears state, HI, LO, counter, operands
//   bus   : muldiv_unit_if.slave (Start, MDOp, A, B, ReadSel in;
//           Busy, MULDIVOut out)
// A mult/div accepted in IDLE latches its operands and runs for MULT_CYCLES
// or DIV_CYCLES cycles; HI/LO are written only at the final edge. mthi/mtlo
// write immediately and never raise Busy.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    md_op_e        op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the latched operands only.
    // ------------------------------------------------------------------
    logic [63:0] prod_s, prod_u;
    logic        is_signed_div, div_by_zero, neg_q, neg_r;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special
    // case: |0x80000000| is 0x80000000 unsigned, and negating it wraps back.
    assign is_signed_div = (op_q == OP_DIV);
    assign div_by_zero   = (b_q == 32'd0);
    assign a_mag         = (is_signed_div && a_q[31]) ? -a_q : a_q;
    assign b_mag         = (is_signed_div && b_q[31]) ? -b_q : b_q;
    assign b_safe        = div_by_zero ? 32'd1 : b_mag;  // keeps / and % defined
    assign q_mag         = a_mag / b_safe;
    assign r_mag         = a_mag % b_safe;
    assign neg_q         = is_signed_div && (a_q[31] ^ b_q[31]);
    assign neg_r         = is_signed_div && a_q[31];
    assign quot          = neg_q ? -q_mag : q_mag;
    assign rem           = neg_r ? -r_mag : r_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    unique case (md_op_e'(bus.MDOp))
                        OP_MULT, OP_MULTU: begin
                            op_d    = md_op_e'(bus.MDOp);
                            a_d     = bus.A;
                            b_d     = bus.B;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = md_op_e'(bus.MDOp);
                            a_d     = bus.A;
                            b_d     = bus.B;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;  // OP_NONE / OP_RSVD: no effect
                    endcase
                end
            end

            S_RUN: begin
                // Start is ignored here; the pipeline stalls the instruction.
                if (cnt_q == CW'(1)) begin
                    unique case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still burns the full window but
                            // leaves HI/LO untouched.
                            if (!div_by_zero) begin
                                lo_d = quot;
                                hi_d = rem;
                            end
                        end
                        default: ;
                    endcase
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.MULDIVOut = bus.ReadSel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same offset, well away
// from the next active edge.
module tb_muldiv_unit;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    // Expected committed HI/LO, maintained by the bench from its own constants.
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    muldiv_unit_if bus ();

    muldiv_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.ReadSel = 1'b1;
        #1;
        h = bus.MULDIVOut;
        bus.ReadSel = 1'b0;
        #1;
        l = bus.MULDIVOut;
    endtask

    // Counts further busy cycles until Busy drops, bounded.
    task automatic wait_done(input int start_n, output int n);
        n = start_n;
        while (bus.Busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          n;
        logic [31:0] h, l;
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        // Scramble the operands right after acceptance: the result must come
        // from the latched copies.
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
        bus.A     = ~a;
        bus.B     = ~b;
        check({tag, " busy after start"}, 32'(bus.Busy), 32'd1);
        check({tag, " LO held during run"}, bus.MULDIVOut, cur_lo);
        wait_done(0, n);
        check({tag, " busy cycles"}, 32'(n), 32'(exp_cycles));
        read_hilo(h, l);
        check({tag, " HI"}, h, exp_hi);
        check({tag, " LO"}, l, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
        logic [31:0] h, l;
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        tick();
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
        check({tag, " busy stays low"}, 32'(bus.Busy), 32'd0);
        if (op == OP_MTHI) cur_hi = a;
        if (op == OP_MTLO) cur_lo = a;
        read_hilo(h, l);
        check({tag, " HI"}, h, cur_hi);
        check({tag, " LO"}, l, cur_lo);
    endtask

    initial begin
        int          n;
        logic [31:0] h, l;

        n_vec  = 0;
        n_miss = 0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.MDOp    = OP_NONE;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        bus.ReadSel = 1'b0;

        // Reset state
        #2;
        check("reset busy", 32'(bus.Busy), 32'd0);
        read_hilo(h, l);
        check("reset HI", h, 32'd0);
        check("reset LO", l, 32'd0);
        #8;
        reset = 1'b0;
        tick();

        // Multiply / divide reference vectors
        run_op("mult -1*2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div -7/2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2",   OP_DIVU,  32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);

        // mthi / mtlo, then divide by zero leaves them intact
        move_to("mthi", OP_MTHI, 32'h0000_0011);
        move_to("mtlo", OP_MTLO, 32'h0000_0022);
        run_op("div 5/0",    OP_DIV,   32'h0000_0005, 32'h0000_0000, 10, 32'h0000_0011, 32'h0000_0022);

        // Overflow divide, then back-to-back multu in the cycle after Busy falls
        run_op("div min/-1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("multu 3*4",  OP_MULTU, 32'h0000_0003, 32'h0000_0004, 5,  32'h0000_0000, 32'h0000_000C);

        // MDOp none / reserved with Start in IDLE: no effect
        move_to("op rsvd", OP_RSVD, 32'hAAAA_AAAA);
        move_to("op none", OP_NONE, 32'h5555_5555);

        // Start during RUN is ignored; operand changes mid-run have no effect
        bus.Start = 1'b1;
        bus.MDOp  = OP_DIV;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        tick();                 // accepted; busy cycle 1
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
        tick();                 // busy cycle 2
        bus.Start = 1'b1;
        bus.MDOp  = OP_MTLO;
        bus.A     = 32'h0000_0055;
        bus.B     = 32'd1;
        tick();                 // busy cycle 3
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
        bus.A     = 32'h0000_DEAD;
        bus.B     = 32'd3;
        check("mtlo in run ignored", bus.MULDIVOut, cur_lo);
        wait_done(2, n);
        check("div 100/7 busy cycles", 32'(n), 32'd10);
        read_hilo(h, l);
        check("div 100/7 HI", h, 32'd2);
        check("div 100/7 LO", l, 32'd14);
        cur_hi = 32'd2;
        cur_lo = 32'd14;

        // Asynchronous reset between edges in busy cycle 4 aborts the divide
        bus.Start = 1'b1;
        bus.MDOp  = OP_DIV;
        bus.A     = 32'd9;
        bus.B     = 32'd2;
        tick();                 // busy cycle 1
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
        tick();
        tick();
        tick();                 // busy cycle 4
        #2;
        reset = 1'b1;
        #1;
        check("async reset busy", 32'(bus.Busy), 32'd0);
        check("async reset LO", bus.MULDIVOut, 32'd0);
        bus.ReadSel = 1'b1;
        #1;
        check("async reset HI", bus.MULDIVOut, 32'd0);
        bus.ReadSel = 1'b0;
        reset = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        repeat (12) tick();
        check("no commit after abort busy", 32'(bus.Busy), 32'd0);
        read_hilo(h, l);
        check("no commit after abort HI", h, 32'd0);
        check("no commit after abort LO", l, 32'd0);

        // First start after reset is accepted normally
        run_op("divu after reset", OP_DIVU, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
